imem_boot_controller: RTL and testbench
=======================================

Name: imem_boot_controller

Overview:
- Sequences the instruction-memory boot flow: triggers the instruction loader, owns the single instruction-memory port, and holds the core in reset until the image is written.
- After loading, hands the memory port to the core's fetch interface with a request/acknowledge handshake.
- Sits between the instruction loader, the instruction memory (1-cycle synchronous read) and the core.

Parameters:
ADDR_W, 10, instruction-memory word-address width
DATA_W, 32, instruction word width
LOAD_TIMEOUT, 1023, maximum LOAD-state cycles before fault
RELEASE_DELAY, 4, cycles core reset stays asserted after the load drains (must be ≥1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level request to (re)load; acted on at its rising edge only
loader_load_enable  out  1  enable to loader; high only while in LOAD
loader_addr  in  ADDR_W  loader write address
loader_wr_en  in  1  loader write strobe
loader_data  in  DATA_W  loader write data
loader_done  in  1  loader completion flag
mem_addr  out  ADDR_W  memory address
mem_wr_en  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after the address
cpu_fetch_req  in  1  core fetch request, held until acknowledged
cpu_fetch_addr  in  ADDR_W  core fetch word address
cpu_fetch_ack  out  1  one-cycle fetch acknowledge
cpu_fetch_rdata  out  DATA_W  fetched word, valid while cpu_fetch_ack=1
cpu_rst_n  out  1  core reset, active-low
busy  out  1  high in LOAD, DRAIN or RELEASE
error  out  1  load-timeout fault flag

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - cpu_rst_n=0, loader_load_enable=0, cpu_fetch_ack=0, error=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, cpu_fetch_rdata=0.
  - Edge-detect register, timeout counter, release counter and pending flag all clear.
- Start edge: start_rise = start & ~start_q. start_q is registered every cycle and cleared on reset.
- States:
  - IDLE: cpu_rst_n=0. On start_rise go to LOAD.
  - LOAD:
    - loader_load_enable=1 (registered, rises the cycle LOAD is entered).
    - Memory port is driven combinationally from loader_addr, loader_wr_en and loader_data.
    - Timeout counter increments each cycle.
    - loader_done=1 → DRAIN. This has priority over timeout when both occur in the same cycle.
    - Counter reaching LOAD_TIMEOUT → FAULT.
    - start_rise is ignored.
  - DRAIN: one cycle. Memory is still muxed to the loader so a trailing write lands. loader_load_enable=0. Then go to RELEASE.
  - RELEASE: mem_wr_en=0. Counter counts RELEASE_DELAY cycles with cpu_rst_n=0, then go to RUN.
  - RUN:
    - cpu_rst_n=1, registered, so it rises on the RELEASE→RUN edge.
    - Memory is muxed to the fetch port with mem_wr_en=0.
    - start_rise → LOAD. On that same edge: cpu_rst_n=0, the pending fetch is discarded, and no ack is issued.
  - FAULT:
    - error=1, cpu_rst_n=0, loader_load_enable=0, mem_wr_en=0.
    - start_rise → LOAD, clearing error and the timeout counter.
- Fetch handshake (RUN only):
  - Request accepted when cpu_fetch_req=1 and pending=0. mem_addr=cpu_fetch_addr that cycle and pending is set.
  - Next cycle: cpu_fetch_ack=1, cpu_fetch_rdata=mem_rdata, pending clears.
  - No new accept during an ack cycle, so maximum throughput is one fetch per 2 cycles and latency is 1 cycle.
  - Requests outside RUN are never acknowledged.
- Idle memory drive: when neither the loader nor the fetch port owns memory (IDLE, RELEASE, FAULT, RUN with no accept), mem_addr=0 and mem_wdata=0.
- Mid-operation reset: any state returns to IDLE immediately. cpu_rst_n drops asynchronously, and an in-flight loader write is aborted (mem_wr_en=0).
- Counter width: timeout counter is $clog2(LOAD_TIMEOUT+1) bits and saturates; it does not wrap.

Test Plan:
- Boot: reset_n low→high, pulse start; loader model writes 34 words to addr 0..33, then loader_done → loader_load_enable high for the LOAD duration, all 34 writes reach memory, busy=1, cpu_rst_n rises exactly DRAIN+4 cycles after loader_done.
- Fetch: in RUN, req addr=5 with mem[5]=0x00178793 → ack 1 cycle later with rdata 0x00178793. Req held continuously → acks on alternate cycles with no duplicates.
- Timeout: loader never asserts done → FAULT at LOAD_TIMEOUT cycles, error=1, cpu_rst_n=0. Next start edge → LOAD with error=0 and loader_load_enable re-rising.
- Reload in RUN: start edge while a fetch is pending → no ack, cpu_rst_n=0 on that edge, LOAD re-entered, second boot completes with new image.
- Abuse: start held high (single edge only), start toggled during LOAD (ignored), loader_done and timeout in the same cycle (→ DRAIN, error=0).
- Async reset mid-LOAD and mid-fetch → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imem_boot_controller.sv
// rtl/imem_boot_controller.sv - instruction-memory boot sequencer and fetch port arbiter
module imem_boot_controller #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int LOAD_TIMEOUT  = 1023,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              loader_load_enable,
  input  logic [ADDR_W-1:0] loader_addr,
  input  logic              loader_wr_en,
  input  logic [DATA_W-1:0] loader_data,
  input  logic              loader_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cpu_fetch_req,
  input  logic [ADDR_W-1:0] cpu_fetch_addr,
  output logic              cpu_fetch_ack,
  output logic [DATA_W-1:0] cpu_fetch_rdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              error
);

  localparam int TCW = $clog2(LOAD_TIMEOUT + 1);
  localparam int RCW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [TCW-1:0] TMAX  = TCW'(LOAD_TIMEOUT);
  localparam logic [RCW-1:0] RLAST = RCW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_RELEASE, S_RUN, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic             start_q;
  logic             pending_q, pending_d;
  logic             load_en_q, cpu_rst_n_q, error_q;
  logic             start_rise;
  logic             accept;
  logic             ack;

  assign start_rise = start & ~start_q;
  // Saturating increment so a long LOAD can never wrap back below the limit.
  assign tcnt_inc   = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + TCW'(1);
  // A reload edge wins over the fetch port: nothing is accepted or acknowledged on it.
  assign accept     = (state_q == S_RUN) & cpu_fetch_req & ~pending_q & ~start_rise;
  assign ack        = (state_q == S_RUN) & pending_q & ~start_rise;

  assign loader_load_enable = load_en_q;
  assign cpu_rst_n          = cpu_rst_n_q;
  assign error              = error_q;

  // State, counters, start edge detector and fetch-pending tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      rcnt_q    <= '0;
      start_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      rcnt_q    <= rcnt_d;
      start_q   <= start;
      pending_q <= pending_d;
    end
  end

  // Registered outputs follow the next state so they switch on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      load_en_q   <= (state_d == S_LOAD);
      cpu_rst_n_q <= (state_d == S_RUN);
      error_q     <= (state_d == S_FAULT);
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    rcnt_d    = rcnt_q;
    pending_d = accept;
    case (state_q)
      S_IDLE:    if (start_rise) state_d = S_LOAD;
      S_LOAD: begin
        tcnt_d = tcnt_inc;
        if (loader_done)           state_d = S_DRAIN;
        else if (tcnt_inc == TMAX) state_d = S_FAULT;
      end
      S_DRAIN:   state_d = S_RELEASE;
      S_RELEASE: begin
        if (rcnt_q == RLAST) state_d = S_RUN;
        else                 rcnt_d  = rcnt_q + RCW'(1);
      end
      S_RUN:     if (start_rise) state_d = S_LOAD;
      S_FAULT:   if (start_rise) state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
    if ((state_d == S_LOAD) && (state_q != S_LOAD))       tcnt_d = '0;
    if ((state_d == S_RELEASE) && (state_q != S_RELEASE)) rcnt_d = '0;
  end

  // Memory port ownership, fetch response and busy flag
  always_comb begin
    mem_addr        = '0;
    mem_wr_en       = 1'b0;
    mem_wdata       = '0;
    cpu_fetch_ack   = 1'b0;
    cpu_fetch_rdata = '0;
    busy            = 1'b0;
    case (state_q)
      S_LOAD, S_DRAIN: begin
        mem_addr  = loader_addr;
        mem_wr_en = loader_wr_en;
        mem_wdata = loader_data;
        busy      = 1'b1;
      end
      S_RELEASE: busy = 1'b1;
      S_RUN: begin
        if (accept) mem_addr = cpu_fetch_addr;
        if (ack) begin
          cpu_fetch_ack   = 1'b1;
          cpu_fetch_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_controller.sv
// tb/tb_imem_boot_controller.sv - self-checking bench for imem_boot_controller
module tb_imem_boot_controller;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;
  localparam int LOAD_TIMEOUT  = 1023;
  localparam int RELEASE_DELAY = 4;
  localparam int NWORDS        = 34;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              loader_load_enable;
  logic [ADDR_W-1:0] loader_addr;
  logic              loader_wr_en;
  logic [DATA_W-1:0] loader_data;
  logic              loader_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_fetch_req;
  logic [ADDR_W-1:0] cpu_fetch_addr;
  logic              cpu_fetch_ack;
  logic [DATA_W-1:0] cpu_fetch_rdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              error;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_img [0:NWORDS-1];
  int nwr  = 0;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imem_boot_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LOAD_TIMEOUT(LOAD_TIMEOUT), .RELEASE_DELAY(RELEASE_DELAY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .loader_load_enable(loader_load_enable), .loader_addr(loader_addr),
    .loader_wr_en(loader_wr_en), .loader_data(loader_data), .loader_done(loader_done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_fetch_req(cpu_fetch_req), .cpu_fetch_addr(cpu_fetch_addr),
    .cpu_fetch_ack(cpu_fetch_ack), .cpu_fetch_rdata(cpu_fetch_rdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .error(error)
  );

  // Instruction memory with one-cycle synchronous read
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      nwr <= nwr + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_load_en"}, loader_load_enable, 0);
    chk({tag, "_ack"}, cpu_fetch_ack, 0);
    chk({tag, "_rdata"}, cpu_fetch_rdata, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  // Low-then-high start; leaves start high and the controller in its first LOAD cycle
  task automatic start_edge(input string tag);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk({tag, "_load_en"}, loader_load_enable, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
  endtask

  // Loader model: writes NWORDS words (with random gaps), done with the penultimate
  // word, trailing write in the drain cycle, then measures the core release latency.
  task automatic boot(input bit toggle, input bit pin5);
    int i, cyc, base, bad;
    logic [DATA_W-1:0] w;
    base = nwr;
    i = 0;
    while (i < NWORDS - 2) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        loader_wr_en = 1'b0;
      end else begin
        w = $urandom;
        if (pin5 && i == 5) w = 32'h00178793;
        exp_img[i]   = w;
        loader_addr  = ADDR_W'(i);
        loader_data  = w;
        loader_wr_en = 1'b1;
        i++;
      end
      #1;
      chk("load_mux_wr", mem_wr_en, loader_wr_en);
      if (loader_wr_en) chk("load_mux_addr", mem_addr, loader_addr);
      step();
      chk("load_en_in_load", loader_load_enable, 1);
      chk("busy_in_load", busy, 1);
      chk("cpu_rst_in_load", cpu_rst_n, 0);
    end
    w = $urandom;
    exp_img[NWORDS-2] = w;
    loader_addr  = ADDR_W'(NWORDS - 2);
    loader_data  = w;
    loader_wr_en = 1'b1;
    loader_done  = 1'b1;
    if (toggle) start = 1'b0;
    step();
    w = $urandom;
    exp_img[NWORDS-1] = w;
    loader_addr  = ADDR_W'(NWORDS - 1);
    loader_data  = w;
    loader_done  = 1'b0;
    #1;
    chk("drain_load_en", loader_load_enable, 0);
    chk("drain_busy", busy, 1);
    chk("drain_trailing_wr", mem_wr_en, 1);
    chk("drain_trailing_addr", mem_addr, NWORDS - 1);
    step();
    loader_addr = '0;
    loader_data = $urandom;
    cyc = 1;
    while (cpu_rst_n !== 1'b1 && cyc < 30) begin
      chk("release_busy", busy, 1);
      chk("release_no_wr", mem_wr_en, 0);
      step();
      cyc++;
    end
    loader_wr_en = 1'b0;
    chk("release_latency", cyc, 1 + RELEASE_DELAY);
    chk("run_busy", busy, 0);
    chk("run_load_en", loader_load_enable, 0);
    chk("write_count", nwr - base, NWORDS);
    bad = 0;
    for (int k = 0; k < NWORDS; k++) if (mem[k] !== exp_img[k]) bad++;
    chk("image_words_bad", bad, 0);
  endtask

  // Core model holding fetch_req continuously; acks expected on alternate cycles
  task automatic fetch_run(input int cycles);
    bit acc_prev, acc_now;
    int a_prev, nack;
    acc_prev = 1'b0;
    a_prev   = 0;
    nack     = 0;
    cpu_fetch_req  = 1'b1;
    cpu_fetch_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
    for (int c = 0; c < cycles; c++) begin
      #1;
      chk("fetch_ack", cpu_fetch_ack, acc_prev);
      if (acc_prev) begin
        chk("fetch_rdata", cpu_fetch_rdata, exp_img[a_prev]);
        nack++;
      end
      acc_now = !acc_prev;
      chk("fetch_mem_addr", mem_addr, acc_now ? 64'(cpu_fetch_addr) : 64'd0);
      chk("fetch_no_wr", mem_wr_en, 0);
      if (acc_now) a_prev = int'(cpu_fetch_addr);
      else cpu_fetch_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
      acc_prev = acc_now;
      step();
    end
    cpu_fetch_req = 1'b0;
    chk("fetch_count", nack, cycles / 2);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0;
    start = 1'b0;
    loader_addr = '0;
    loader_wr_en = 1'b0;
    loader_data = '0;
    loader_done = 1'b0;
    cpu_fetch_req = 1'b0;
    cpu_fetch_addr = '0;
    repeat (3) step();
    chk_reset("por");
    reset_n = 1'b1;
    step();
    chk("idle_cpu_rst", cpu_rst_n, 0);
    chk("idle_busy", busy, 0);

    // First boot with start held high afterwards: only one edge counts
    start_edge("boot1");
    boot(1'b0, 1'b1);
    repeat (3) step();
    chk("held_start_run", cpu_rst_n, 1);
    chk("held_start_no_load", loader_load_enable, 0);

    // Single fetch of word 5, then back-to-back held requests
    cpu_fetch_req = 1'b1;
    cpu_fetch_addr = ADDR_W'(5);
    #1;
    chk("f5_mem_addr", mem_addr, 5);
    step();
    chk("f5_ack", cpu_fetch_ack, 1);
    chk("f5_rdata", cpu_fetch_rdata, 32'h00178793);
    cpu_fetch_req = 1'b0;
    step();
    chk("f5_ack_once", cpu_fetch_ack, 0);
    fetch_run(20);

    // Reload while a fetch is pending
    start = 1'b0;
    step();
    cpu_fetch_req = 1'b1;
    cpu_fetch_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
    step();
    start = 1'b1;
    #1;
    chk("reload_no_ack", cpu_fetch_ack, 0);
    step();
    chk("reload_cpu_rst", cpu_rst_n, 0);
    chk("reload_load_en", loader_load_enable, 1);
    chk("reload_ack", cpu_fetch_ack, 0);
    cpu_fetch_req = 1'b0;
    boot(1'b1, 1'b0);
    fetch_run(12);

    // Load timeout with start toggling and a request outside RUN
    start_edge("tmo");
    cpu_fetch_req = 1'b1;
    cnt = 0;
    while (error !== 1'b1 && cnt < LOAD_TIMEOUT + 50) begin
      start = 1'($urandom_range(0, 1));
      step();
      cnt++;
    end
    chk("timeout_cycles", cnt, LOAD_TIMEOUT);
    chk("fault_error", error, 1);
    chk("fault_cpu_rst", cpu_rst_n, 0);
    chk("fault_load_en", loader_load_enable, 0);
    chk("fault_busy", busy, 0);
    chk("fault_no_ack", cpu_fetch_ack, 0);
    step();
    chk("fault_holds", error, 1);
    cpu_fetch_req = 1'b0;
    start_edge("fault_restart");
    boot(1'b0, 1'b0);

    // loader_done in the very cycle the timeout would fire
    start_edge("coincide");
    repeat (LOAD_TIMEOUT - 1) step();
    chk("coincide_pre_error", error, 0);
    chk("coincide_pre_busy", busy, 1);
    loader_done = 1'b1;
    step();
    loader_done = 1'b0;
    chk("coincide_error", error, 0);
    chk("coincide_drain_busy", busy, 1);
    chk("coincide_load_en", loader_load_enable, 0);
    cnt = 0;
    while (cpu_rst_n !== 1'b1 && cnt < 30) begin
      step();
      cnt++;
    end
    chk("coincide_run", cpu_rst_n, 1);
    chk("coincide_run_error", error, 0);

    // Asynchronous reset in the middle of a loader write
    start_edge("mid_load");
    loader_addr = ADDR_W'(3);
    loader_data = $urandom;
    loader_wr_en = 1'b1;
    #1;
    chk("mid_load_wr", mem_wr_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async_load");
    loader_wr_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Asynchronous reset during a fetch acknowledge
    start_edge("mid_fetch");
    boot(1'b0, 1'b0);
    cpu_fetch_req = 1'b1;
    cpu_fetch_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
    step();
    chk("mid_fetch_ack", cpu_fetch_ack, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async_fetch");
    cpu_fetch_req = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", cpu_rst_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
